mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage. It is the receiving end of the EX→MEM valid/allowin handshake and of the data SRAM read path.
- Latches the EX payload and captures the SRAM read data returned one cycle after the request.
- Selects the load or ALU result and hands a writeback payload to WB.
- Publishes a forwarding bundle back to ID.

Parameters:
- EX_TO_MEM_WIDTH, 107, width of incoming payload: {rf_we[1], rf_waddr[5], pc[32], alu_result[32], rkd_value[32], res_from_mem[1], mem_we[4]}, MSB first.
- MEM_TO_WB_WIDTH, 70, width of outgoing payload: {rf_we[1], rf_waddr[5], pc[32], final_result[32]}, MSB first.

Ports:
- clk  in  1  Single clock.
- resetn  in  1  Asynchronous active-low reset.
- mem_allowin  out  1  Stage can accept a new instruction this cycle.
- ex_to_mem_wire  in  EX_TO_MEM_WIDTH  EX payload.
- ex_to_mem_valid  in  1  EX payload valid.
- wb_allowin  in  1  WB can accept.
- mem_to_wb_wire  out  MEM_TO_WB_WIDTH  WB payload.
- mem_to_wb_valid  out  1  WB payload valid.
- data_sram_rdata  in  32  SRAM read data, valid in the cycle after the request edge.
- mem_rf_zip  out  38  Forwarding bundle to ID: {rf_we&mem_valid[1], rf_waddr[5], final_result[32]}.

Behaviour:
- Reset (async, resetn=0):
  - mem_valid, payload register, first_cycle flag and rdata_hold clear to 0.
  - Consequent outputs: mem_allowin=1, mem_to_wb_valid=0, mem_to_wb_wire=0, mem_rf_zip=0.
- Handshake:
  - mem_ready_go=1.
  - mem_allowin = ~mem_valid | wb_allowin.
  - mem_to_wb_valid = mem_valid.
- mem_valid update: on a posedge with mem_allowin=1, mem_valid <= ex_to_mem_valid. Otherwise it holds.
- Payload register: loads ex_to_mem_wire only on a posedge with ex_to_mem_valid & mem_allowin. Otherwise it holds, including when mem_allowin=1 and ex_to_mem_valid=0.
- first_cycle flag:
  - Set to 1 on every payload load.
  - Cleared on any other posedge.
  - While first_cycle=1, data_sram_rdata carries this instruction's data.
- rdata_hold: on a posedge with first_cycle=1, rdata_hold <= data_sram_rdata. The SRAM may be re-driven by the next EX instruction while MEM stalls, so the captured value must survive.
- load_data = first_cycle ? data_sram_rdata : rdata_hold. This is 0-latency on the first cycle and stable across any number of wb_allowin=0 stall cycles.
- Result selection: final_result = res_from_mem ? load_data : alu_result. Word loads only; no byte/half extraction or sign extension.
- mem_to_wb_wire = {rf_we, rf_waddr, pc, final_result}. The wire is not gated by valid; consumers use mem_to_wb_valid.
- mem_rf_zip gates only rf_we with mem_valid. waddr and result pass through raw.
- Stores (mem_we≠0, res_from_mem=0): result is alu_result. rdata is ignored but still captured, which is harmless.
- Simultaneous events:
  - Leaving and entering in the same cycle (mem_valid=1, wb_allowin=1, ex_to_mem_valid=1): the new payload loads and first_cycle=1 again.
  - Back-to-back loads must each see their own rdata.
- Bubble: mem_valid=1, wb_allowin=1, ex_to_mem_valid=0 → mem_valid goes to 0 and the payload is retained. Outputs are ignored downstream via valid.
- Reset asserted mid-stall: all state clears immediately (async). After release, the stage is empty and accepts on the first edge.
- No combinational path from ex_to_mem_wire to any output. mem_allowin depends combinationally only on mem_valid and wb_allowin.

Test Plan:
- Reset → mem_allowin=1, mem_to_wb_valid=0, mem_rf_zip=0. Assert resetn=0 mid-stall → outputs return to these values without a clock edge.
- ALU op: rf_we=1, waddr=5, alu_result=0x12345678, res_from_mem=0, wb_allowin=1 → one cycle later mem_to_wb_valid=1, final_result=0x12345678, zip={1,5,0x12345678}.
- Load, no stall: res_from_mem=1, rdata=0xDEADBEEF in the first MEM cycle → final_result=0xDEADBEEF in that same cycle.
- Load with 3-cycle stall: wb_allowin=0 for 3 cycles; rdata becomes 0x0BADF00D in cycle 2 → final_result stays 0xDEADBEEF for all stall cycles and mem_allowin=0 throughout.
- Back-to-back loads, rdata 0x11111111 then 0x22222222, wb_allowin=1 → WB sees 0x11111111 then 0x22222222 on consecutive cycles.
- Bubble: ex_to_mem_valid=0 after one instruction → mem_to_wb_valid falls to 0 and zip rf_we bit=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the EX->MEM handshake, the MEM->WB handshake, the
// data SRAM read return and the ID forwarding bundle of the memory stage.
//   ex_to_mem_wire / ex_to_mem_valid : payload and valid from EX
//   mem_allowin                      : MEM can accept from EX
//   wb_allowin                       : WB can accept from MEM
//   mem_to_wb_wire / mem_to_wb_valid : payload and valid to WB
//   data_sram_rdata                  : SRAM read data, one cycle after request
//   mem_rf_zip                       : {rf_we&valid, rf_waddr, final_result} to ID
// Modports: slave = the memory stage, master = its environment.
interface mem_stage_if #(
    parameter int EX_TO_MEM_WIDTH = 107,
    parameter int MEM_TO_WB_WIDTH = 70
);
    logic                       mem_allowin;
    logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_wire;
    logic                       ex_to_mem_valid;
    logic                       wb_allowin;
    logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_wire;
    logic                       mem_to_wb_valid;
    logic [31:0]                data_sram_rdata;
    logic [37:0]                mem_rf_zip;

    modport slave (
        input  ex_to_mem_wire, ex_to_mem_valid, wb_allowin, data_sram_rdata,
        output mem_allowin, mem_to_wb_wire, mem_to_wb_valid, mem_rf_zip
    );

    modport master (
        output ex_to_mem_wire, ex_to_mem_valid, wb_allowin, data_sram_rdata,
        input  mem_allowin, mem_to_wb_wire, mem_to_wb_valid, mem_rf_zip
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Latches the EX payload, uses the SRAM read data that arrives in the first
// MEM cycle (and holds it across WB stalls), selects load data or ALU result,
// and drives the WB payload plus the ID forwarding bundle.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : mem_stage_if.slave (EX/WB handshakes, SRAM rdata, forwarding)
// Incoming payload layout (MSB first):
//   {rf_we[1], rf_waddr[5], pc[32], alu_result[32], rkd_value[32],
//    res_from_mem[1], mem_we[4]}
// Outgoing payload layout: {rf_we[1], rf_waddr[5], pc[32], final_result[32]}
module mem_stage #(
    parameter int EX_TO_MEM_WIDTH = 107,
    parameter int MEM_TO_WB_WIDTH = 70
) (
    input  logic           clk,
    input  logic           resetn,
    mem_stage_if.slave     bus
);
    logic                       mem_valid;
    logic                       mem_ready_go;
    logic                       mem_allowin;
    logic                       load_en;
    logic [EX_TO_MEM_WIDTH-1:0] payload;
    logic                       first_cycle;
    logic [31:0]                rdata_hold;

    logic                       rf_we;
    logic [4:0]                 rf_waddr;
    logic [31:0]                pc;
    logic [31:0]                alu_result;
    logic [31:0]                rkd_value;
    logic                       res_from_mem;
    logic [3:0]                 mem_we;
    logic [31:0]                load_data;
    logic [31:0]                final_result;
    logic [MEM_TO_WB_WIDTH-1:0] wb_payload;
    logic                       unused_fields;

    // Handshake: the stage always completes in one cycle.
    assign mem_ready_go = 1'b1;
    assign mem_allowin  = ~mem_valid | (mem_ready_go & bus.wb_allowin);
    assign load_en      = bus.ex_to_mem_valid & mem_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= bus.ex_to_mem_valid;
        end
    end

    // Payload is retained on a bubble; only a real accept overwrites it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            payload <= '0;
        end else if (load_en) begin
            payload <= bus.ex_to_mem_wire;
        end
    end

    // first_cycle marks the cycle in which the SRAM returns this
    // instruction's data; afterwards the SRAM may belong to the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            first_cycle <= 1'b0;
        end else begin
            first_cycle <= load_en;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_hold <= '0;
        end else if (first_cycle) begin
            rdata_hold <= bus.data_sram_rdata;
        end
    end

    // Field decode
    assign rf_we        = payload[106];
    assign rf_waddr     = payload[105:101];
    assign pc           = payload[100:69];
    assign alu_result   = payload[68:37];
    assign rkd_value    = payload[36:5];
    assign res_from_mem = payload[4];
    assign mem_we       = payload[3:0];

    // Store data and byte enables were consumed by EX's SRAM request.
    assign unused_fields = ^{rkd_value, mem_we};

    // Zero-latency on the first cycle, stable from the hold register after.
    assign load_data    = first_cycle ? bus.data_sram_rdata : rdata_hold;
    assign final_result = res_from_mem ? load_data : alu_result;

    assign wb_payload   = {rf_we, rf_waddr, pc, final_result};

    assign bus.mem_allowin     = mem_allowin;
    assign bus.mem_to_wb_valid = mem_valid & mem_ready_go;
    assign bus.mem_to_wb_wire  = wb_payload;
    assign bus.mem_rf_zip      = {rf_we & mem_valid, rf_waddr, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level model
// (what instruction sits in MEM, which SRAM word it saw on arrival) checked
// every cycle, plus literal expectations at the key points.
module tb_mem_stage;
    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rkd;
        logic        res;
        logic [3:0]  mwe;
    } inst_t;

    logic clk;
    logic resetn;
    int unsigned n_checks;
    int unsigned n_pass;

    mem_stage_if #(.EX_TO_MEM_WIDTH(107), .MEM_TO_WB_WIDTH(70)) bus ();

    mem_stage #(.EX_TO_MEM_WIDTH(107), .MEM_TO_WB_WIDTH(70)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model state: which instruction is in MEM and how long it has been there.
    inst_t       cur_in;
    logic        m_valid;
    inst_t       m_inst;
    int unsigned m_age;
    logic [31:0] m_load;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid = 1'b0;
            m_age   = 1;
        end else begin
            if (!m_valid || bus.wb_allowin) begin
                m_valid = bus.ex_to_mem_valid;
                if (bus.ex_to_mem_valid) begin
                    m_inst = cur_in;
                    m_age  = 0;
                end else begin
                    m_age = m_age + 1;
                end
            end else begin
                m_age = m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] fin;
        if (resetn) begin
            if (m_valid && m_age == 0) m_load = bus.data_sram_rdata;
            chk("allowin", 128'(bus.mem_allowin), 128'(!m_valid || bus.wb_allowin));
            chk("wb_valid", 128'(bus.mem_to_wb_valid), 128'(m_valid));
            chk("zip_we", 128'(bus.mem_rf_zip[37]), 128'(m_valid & m_inst.we));
            if (m_valid) begin
                fin = m_inst.res ? m_load : m_inst.alu;
                chk("wb_wire", 128'(bus.mem_to_wb_wire),
                    128'({m_inst.we, m_inst.waddr, m_inst.pc, fin}));
                chk("zip_body", 128'(bus.mem_rf_zip[36:0]), 128'({m_inst.waddr, fin}));
            end
        end
    end

    function automatic inst_t mk(input logic we, input logic [4:0] wa, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic res, input logic [3:0] mwe);
        inst_t t;
        t.we = we; t.waddr = wa; t.pc = pc; t.alu = alu;
        t.rkd = 32'hA5A5_0000 ^ alu; t.res = res; t.mwe = mwe;
        return t;
    endfunction

    // Drive one cycle's inputs just after the edge, return at the negedge.
    task automatic step(input logic ev, input inst_t t, input logic wba, input logic [31:0] rd);
        @(posedge clk);
        #1;
        cur_in               = t;
        bus.ex_to_mem_valid  = ev;
        bus.ex_to_mem_wire   = t;
        bus.wb_allowin       = wba;
        bus.data_sram_rdata  = rd;
        @(negedge clk);
        #1;
    endtask

    inst_t alu1, ld1, ld2, alu3, ld4, ld5, st1, alu6, none;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_valid  = 1'b0;
        m_age    = 1;
        m_load   = '0;
        alu1 = mk(1'b1, 5'd5,  32'h1C00_0000, 32'h1234_5678, 1'b0, 4'h0);
        ld1  = mk(1'b1, 5'd7,  32'h1C00_0004, 32'h0000_0100, 1'b1, 4'h0);
        ld2  = mk(1'b1, 5'd8,  32'h1C00_0008, 32'h0000_0200, 1'b1, 4'h0);
        alu3 = mk(1'b1, 5'd3,  32'h1C00_000C, 32'hCAFE_0003, 1'b0, 4'h0);
        ld4  = mk(1'b1, 5'd9,  32'h1C00_0010, 32'h0000_0400, 1'b1, 4'h0);
        ld5  = mk(1'b1, 5'd10, 32'h1C00_0014, 32'h0000_0500, 1'b1, 4'h0);
        st1  = mk(1'b0, 5'd0,  32'h1C00_0018, 32'h0000_0300, 1'b0, 4'hF);
        alu6 = mk(1'b1, 5'd6,  32'h1C00_001C, 32'h6666_0006, 1'b0, 4'h0);
        none = '0;
        cur_in = none;

        resetn              = 1'b0;
        bus.ex_to_mem_valid = 1'b0;
        bus.ex_to_mem_wire  = '0;
        bus.wb_allowin      = 1'b1;
        bus.data_sram_rdata = '0;
        #12;
        chk("rst_allowin", 128'(bus.mem_allowin), 128'(1));
        chk("rst_valid", 128'(bus.mem_to_wb_valid), 128'(0));
        chk("rst_zip", 128'(bus.mem_rf_zip), 128'(0));
        chk("rst_wire", 128'(bus.mem_to_wb_wire), 128'(0));
        #10 resetn = 1'b1;

        step(1'b1, alu1, 1'b1, 32'h0);
        step(1'b0, none, 1'b1, 32'h0);
        chk("alu_valid", 128'(bus.mem_to_wb_valid), 128'(1));
        chk("alu_zip", 128'(bus.mem_rf_zip), 128'({1'b1, 5'd5, 32'h1234_5678}));
        chk("alu_final", 128'(bus.mem_to_wb_wire[31:0]), 128'(32'h1234_5678));

        step(1'b1, ld1, 1'b1, 32'h0);
        chk("bubble_valid", 128'(bus.mem_to_wb_valid), 128'(0));
        chk("bubble_zip_we", 128'(bus.mem_rf_zip[37]), 128'(0));
        chk("bubble_retained", 128'(bus.mem_to_wb_wire[31:0]), 128'(32'h1234_5678));

        step(1'b0, none, 1'b1, 32'hDEAD_BEEF);
        chk("load_nostall", 128'(bus.mem_to_wb_wire[31:0]), 128'(32'hDEAD_BEEF));

        step(1'b1, ld2, 1'b1, 32'h0);
        step(1'b0, none, 1'b0, 32'hDEAD_BEEF);
        chk("stall1_final", 128'(bus.mem_to_wb_wire[31:0]), 128'(32'hDEAD_BEEF));
        chk("stall1_allowin", 128'(bus.mem_allowin), 128'(0));
        step(1'b1, alu3, 1'b0, 32'h0BAD_F00D);
        chk("stall2_final", 128'(bus.mem_to_wb_wire[31:0]), 128'(32'hDEAD_BEEF));
        chk("stall2_allowin", 128'(bus.mem_allowin), 128'(0));
        step(1'b1, alu3, 1'b0, 32'h0BAD_F00D);
        chk("stall3_final", 128'(bus.mem_to_wb_wire[31:0]), 128'(32'hDEAD_BEEF));
        chk("stall3_allowin", 128'(bus.mem_allowin), 128'(0));
        step(1'b1, alu3, 1'b1, 32'h0BAD_F00D);
        chk("release_final", 128'(bus.mem_to_wb_wire[31:0]), 128'(32'hDEAD_BEEF));

        step(1'b1, ld4, 1'b1, 32'h0);
        chk("alu3_final", 128'(bus.mem_to_wb_wire[31:0]), 128'(32'hCAFE_0003));
        step(1'b1, ld5, 1'b1, 32'h1111_1111);
        chk("b2b_first", 128'(bus.mem_rf_zip), 128'({1'b1, 5'd9, 32'h1111_1111}));
        step(1'b0, none, 1'b1, 32'h2222_2222);
        chk("b2b_second", 128'(bus.mem_rf_zip), 128'({1'b1, 5'd10, 32'h2222_2222}));

        step(1'b1, st1, 1'b1, 32'h3333_3333);
        step(1'b0, none, 1'b0, 32'h5555_5555);
        chk("store_final", 128'(bus.mem_to_wb_wire[31:0]), 128'(32'h0000_0300));
        chk("store_zip_we", 128'(bus.mem_rf_zip[37]), 128'(0));
        step(1'b0, none, 1'b0, 32'h7777_7777);
        chk("store_stall_valid", 128'(bus.mem_to_wb_valid), 128'(1));

        // Asynchronous reset mid-stall, checked before any clock edge.
        resetn = 1'b0;
        #1;
        chk("arst_allowin", 128'(bus.mem_allowin), 128'(1));
        chk("arst_valid", 128'(bus.mem_to_wb_valid), 128'(0));
        chk("arst_zip", 128'(bus.mem_rf_zip), 128'(0));
        @(posedge clk);
        #2;
        cur_in              = alu6;
        bus.ex_to_mem_valid = 1'b1;
        bus.ex_to_mem_wire  = alu6;
        bus.wb_allowin      = 1'b1;
        resetn              = 1'b1;
        step(1'b0, none, 1'b1, 32'h0);
        chk("post_rst_valid", 128'(bus.mem_to_wb_valid), 128'(1));
        chk("post_rst_zip", 128'(bus.mem_rf_zip), 128'({1'b1, 5'd6, 32'h6666_0006}));
        step(1'b0, none, 1'b1, 32'h0);
        step(1'b0, none, 1'b1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
